// File: rtl/sram_pkg.sv
// Shared constants for clients of the 1R1W 32x1024 OpenRAM macro.
package sram_pkg;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_ADDR_WIDTH = 10;
  localparam int SRAM_NUM_WMASKS = 4;
  localparam logic [SRAM_NUM_WMASKS-1:0] WMASK_ALL = 4'hF;
endpackage

// File: rtl/sram_fifo_outbuf.sv
// 2-entry register FIFO that catches macro read data; slot[0] is always the head.
module sram_fifo_outbuf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            cnt
);
  logic [1:0][DATA_WIDTH-1:0] slot;
  logic                       out_fire;

  assign out_valid = (cnt != 2'd0);
  assign out_fire  = out_valid && out_ready;
  assign out_data  = slot[0];

  // Caller guarantees in_valid never arrives into a full buffer without a pop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt  <= 2'd0;
      slot <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({in_valid, out_fire})
        2'b10: begin
          if (cnt == 2'd0) slot[0] <= in_data;
          else             slot[1] <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot[0] <= slot[1];
          cnt     <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot[0] <= in_data;
          end else begin
            slot[0] <= slot[1];
            slot[1] <= in_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/sram_stream_fifo.sv
// Valid/ready stream FIFO backed by the 1R1W OpenRAM macro; a 2-entry output
// buffer absorbs the macro's 1-cycle, non-holding read latency.
module sram_stream_fifo
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       flush,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [DATA_WIDTH-1:0]      push_data,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [DATA_WIDTH-1:0]      pop_data,
  output logic [ADDR_WIDTH+1:0]      count,
  output logic                       sram_csb0,
  output logic [SRAM_NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0]      sram_addr0,
  output logic [DATA_WIDTH-1:0]      sram_din0,
  output logic                       sram_csb1,
  output logic [ADDR_WIDTH-1:0]      sram_addr1,
  input  logic [DATA_WIDTH-1:0]      sram_dout1
);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = (ADDR_WIDTH)'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic                  rd_inflight;
  logic [1:0]            ob_cnt;
  logic                  push_fire, pop_fire, rd_issue;
  logic [2:0]            ob_claim;

  assign push_ready = (mem_cnt < DEPTH_C) && !flush;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  // Buffer slots still spoken for after this cycle's pop; a new read may only
  // be issued if one slot stays free for it to land in.
  assign ob_claim = {1'b0, ob_cnt} + {2'b0, rd_inflight} - {2'b0, pop_fire};
  assign rd_issue = !flush && (mem_cnt != '0) && (ob_claim < 3'd2);

  assign sram_csb0   = !push_fire;
  assign sram_wmask0 = push_fire ? WMASK_ALL : '0;
  assign sram_addr0  = wr_ptr;
  assign sram_din0   = push_fire ? push_data : '0;
  assign sram_csb1   = !rd_issue;
  assign sram_addr1  = rd_ptr;

  assign count = (ADDR_WIDTH+2)'(mem_cnt) + (ADDR_WIDTH+2)'(rd_inflight)
               + (ADDR_WIDTH+2)'(ob_cnt);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_issue)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      rd_inflight <= rd_issue;
      mem_cnt     <= mem_cnt + (ADDR_WIDTH+1)'(push_fire) - (ADDR_WIDTH+1)'(rd_issue);
    end
  end

  // dout1 is only valid at the edge right after issue, so it is captured
  // unconditionally whenever a read is in flight.
  sram_fifo_outbuf #(.DATA_WIDTH(DATA_WIDTH)) u_outbuf (
    .clk       (clk),
    .nrst      (nrst),
    .flush     (flush),
    .in_valid  (rd_inflight),
    .in_data   (sram_dout1),
    .out_valid (pop_valid),
    .out_ready (pop_ready),
    .out_data  (pop_data),
    .cnt       (ob_cnt)
  );
endmodule

// File: tb/tb_sram_stream_fifo.sv
// Scoreboard bench for sram_stream_fifo with a behavioural SRAM macro model.
module tb_sram_stream_fifo;
  import sram_pkg::*;
  localparam int DW = 32, AW = 10, DEPTH = 1024;

  logic clk = 1'b0, nrst = 1'b0, flush = 1'b0;
  logic push_valid = 1'b0, pop_ready = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic push_ready, pop_valid, sram_csb0, sram_csb1;
  logic [DW-1:0] pop_data, sram_din0, sram_dout1;
  logic [AW+1:0] count;
  logic [SRAM_NUM_WMASKS-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0, sram_addr1;

  sram_stream_fifo dut (
    .clk(clk), .nrst(nrst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count),
    .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
    .sram_dout1(sram_dout1)
  );

  always #5 clk = ~clk;

  // Macro model: read data appears after the edge that samples the request and
  // is replaced by garbage one edge later.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_csb0 && sram_wmask0 == WMASK_ALL) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    else            sram_dout1 <= $urandom;
  end

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents plus running counts of writes, reads, pops.
  logic [DW-1:0] exp_q[$];
  int unsigned wr_n = 0, rd_n = 0, pop_n = 0, tot_pop = 0;

  always @(negedge clk) begin
    if (!nrst) begin
      exp_q.delete(); wr_n = 0; rd_n = 0; pop_n = 0;
    end else begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("outstanding_le2", 64'((rd_n - pop_n) <= 2), 64'd1);
      if (exp_q.size() < DEPTH && !flush) chk("push_ready_space", 64'(push_ready), 64'd1);
      if (exp_q.size() >= DEPTH + 2) chk("push_ready_full", 64'(push_ready), 64'd0);
      if (exp_q.size() == 0) chk("pop_valid_empty", 64'(pop_valid), 64'd0);
      chk("csb0", 64'(sram_csb0), 64'(!(push_valid && push_ready)));
      if (!sram_csb0) begin
        chk("addr0", 64'(sram_addr0), 64'(wr_n % DEPTH));
        chk("din0", 64'(sram_din0), 64'(push_data));
        chk("wmask0", 64'(sram_wmask0), 64'hF);
      end
      if (flush) chk("csb1_flush", 64'(sram_csb1), 64'd1);
      if (!sram_csb1) begin
        chk("addr1", 64'(sram_addr1), 64'(rd_n % DEPTH));
        chk("read_written", 64'(rd_n < wr_n), 64'd1);
      end
      if (pop_valid && pop_ready && !flush) begin
        if (exp_q.size() == 0) chk("pop_underflow", 64'(pop_data), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("pop_data", 64'(pop_data), 64'(exp_q.pop_front()));
      end
      if (flush) begin
        exp_q.delete(); wr_n = 0; rd_n = 0; pop_n = 0;
      end else begin
        if (push_valid && push_ready) begin exp_q.push_back(push_data); wr_n++; end
        if (!sram_csb1) rd_n++;
        if (pop_valid && pop_ready) begin pop_n++; tot_pop++; end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int base, gaps, lo, n;
    // reset state
    repeat (3) step();
    chk("rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_csb0", 64'(sram_csb0), 64'd1);
    chk("rst_csb1", 64'(sram_csb1), 64'd1);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_pop_data", 64'(pop_data), 64'd0);
    nrst = 1'b1; step();

    // latency: edge 0 accepts, pop_valid after edge 2, empty after edge 3
    push_valid = 1'b1; push_data = 32'hDEADBEEF; pop_ready = 1'b1; step();
    push_valid = 1'b0;
    chk("lat_c1_valid", 64'(pop_valid), 64'd0);
    step(); chk("lat_c2_valid", 64'(pop_valid), 64'd0);
    step(); chk("lat_c3_valid", 64'(pop_valid), 64'd1);
    chk("lat_c3_data", 64'(pop_data), 64'hDEADBEEF);
    step(); chk("lat_c4_count", 64'(count), 64'd0);
    chk("lat_c4_valid", 64'(pop_valid), 64'd0);

    // streaming with wrap, no gaps once the first word is out
    base = tot_pop; gaps = 0;
    for (int i = 0; i < 2000; i++) begin
      push_valid = 1'b1; push_data = i; step();
      if (tot_pop - base > 0 && tot_pop - base < 2000 && !pop_valid) gaps++;
    end
    push_valid = 1'b0; n = 0;
    while (tot_pop - base < 2000 && n < 100) begin
      step(); n++;
      if (tot_pop - base > 0 && tot_pop - base < 2000 && !pop_valid) gaps++;
    end
    chk("stream_all_popped", 64'(tot_pop - base), 64'd2000);
    chk("stream_gaps", 64'(gaps), 64'd0);

    // full
    pop_ready = 1'b0; lo = 0;
    for (int i = 0; i < 1030; i++) begin
      push_valid = 1'b1; push_data = $urandom; #1;
      if (!sram_csb0) lo++;
      step();
    end
    push_valid = 1'b0;
    chk("full_count", 64'(count), 64'd1026);
    chk("full_push_ready", 64'(push_ready), 64'd0);
    chk("full_writes", 64'(lo), 64'd1026);

    // flush with a read in flight
    pop_ready = 1'b1; step();
    pop_ready = 1'b0; flush = 1'b1; #1;
    chk("flush_csb0", 64'(sram_csb0), 64'd1);
    chk("flush_csb1", 64'(sram_csb1), 64'd1);
    step(); flush = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_pop_valid", 64'(pop_valid), 64'd0);
    push_valid = 1'b1; push_data = 32'h12345678; step();
    push_valid = 1'b0; n = 0;
    while (!pop_valid && n < 10) begin step(); n++; end
    chk("flush_fresh_valid", 64'(pop_valid), 64'd1);
    chk("flush_fresh_data", 64'(pop_data), 64'h12345678);
    pop_ready = 1'b1; step(); pop_ready = 1'b0;

    // random backpressure: fill phase then drain phase
    for (int i = 0; i < 3000; i++) begin
      push_valid = ($urandom_range(0, 99) < (i < 1500 ? 60 : 15));
      push_data  = $urandom;
      pop_ready  = ($urandom_range(0, 99) < 30);
      flush      = ($urandom_range(0, 999) == 0);
      step();
    end
    push_valid = 1'b0; flush = 1'b0; pop_ready = 1'b1; n = 0;
    while (exp_q.size() != 0 && n < 1200) begin step(); n++; end
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // reset mid-traffic
    for (int i = 0; i < 20; i++) begin
      push_valid = 1'b1; push_data = $urandom; pop_ready = $urandom_range(0, 1); step();
    end
    nrst = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; #1;
    chk("mrst_pop_valid", 64'(pop_valid), 64'd0);
    chk("mrst_count", 64'(count), 64'd0);
    step();
    chk("mrst_csb0", 64'(sram_csb0), 64'd1);
    chk("mrst_csb1", 64'(sram_csb1), 64'd1);
    chk("mrst_push_ready", 64'(push_ready), 64'd1);
    chk("mrst_count_next", 64'(count), 64'd0);
    nrst = 1'b1; step();
    push_valid = 1'b1; push_data = 32'hA5A5_5A5A; pop_ready = 1'b1; step();
    push_valid = 1'b0; n = 0;
    while (!pop_valid && n < 10) begin step(); n++; end
    chk("mrst_after_data", 64'(pop_data), 64'hA5A5_5A5A);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
